// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler that shares one fixed-latency pipelined 16x16 multiplier
// among NUM_REQ requesters and steers each result back to its owner via a tag pipeline.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_in0,
    input  logic [16*NUM_REQ-1:0]   req_in1,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             mul_in0,
    output logic [15:0]             mul_in1,
    output logic                    mul_valid_in,
    input  logic [15:0]             mul_out,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [15:0]             resp_data,
    output logic [ID_W:0]           inflight
);

    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;
    logic            grant_found;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [15:0]     op0 [NUM_REQ];
    logic [15:0]     op1 [NUM_REQ];

    logic            tag_valid_reg [LATENCY];
    logic [ID_W-1:0] tag_id_reg    [LATENCY];
    logic [ID_W:0]   inflight_reg;
    logic            resp_fire;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op0[gi] = req_in0[16*gi +: 16];
            assign op1[gi] = req_in1[16*gi +: 16];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr_reg, k)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_idx(rr_ptr_reg, k);
            end
        end
    end

    // Grants are suppressed while in reset so nothing is issued into a flushed pipe.
    assign grant_valid  = grant_found & ~reset;
    assign req_ready    = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;
    assign mul_valid_in = grant_valid;
    assign mul_in0      = grant_valid ? op0[grant_id] : 16'h0000;
    assign mul_in1      = grant_valid ? op1[grant_id] : 16'h0000;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_valid) begin
            if (grant_id == ID_W'(NUM_REQ - 1))
                rr_ptr_next = '0;
            else
                rr_ptr_next = grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr_reg <= '0;
        else
            rr_ptr_reg <= rr_ptr_next;
    end

    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else if (gi == 0) begin
                    tag_valid_reg[gi] <= grant_valid;
                    tag_id_reg[gi]    <= grant_id;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[(gi == 0) ? 0 : gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    // Last tag stage lines up with mul_out for the op issued LATENCY cycles earlier.
    assign resp_fire = tag_valid_reg[LATENCY-1];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign resp_valid[gi] = resp_fire && (tag_id_reg[LATENCY-1] == ID_W'(gi));
        end
    endgenerate

    assign resp_data = mul_out;

    always_ff @(posedge clk) begin
        if (reset)
            inflight_reg <= '0;
        else if (grant_valid && !resp_fire)
            inflight_reg <= inflight_reg + 1'b1;
        else if (!grant_valid && resp_fire)
            inflight_reg <= inflight_reg - 1'b1;
    end

    assign inflight = inflight_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a 2-stage multiplier model feeds mul_out,
// grants are predicted by a round-robin model and responses are checked against a queue.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_in0;
    logic [16*NUM_REQ-1:0] req_in1;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           mul_in0;
    logic [15:0]           mul_in1;
    logic                  mul_valid_in;
    logic [15:0]           mul_out;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [15:0]           resp_data;
    logic [ID_W:0]         inflight;

    logic [15:0] op0 [NUM_REQ];
    logic [15:0] op1 [NUM_REQ];
    logic [15:0] dsp_p1, dsp_p2;

    typedef struct {
        int          id;
        logic [15:0] prod;
        int          due;
    } exp_t;
    exp_t q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mptr = 0;
    logic [15:0] last_rd = 16'h0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_in0      (req_in0),
        .req_in1      (req_in1),
        .req_ready    (req_ready),
        .mul_in0      (mul_in0),
        .mul_in1      (mul_in1),
        .mul_valid_in (mul_valid_in),
        .mul_out      (mul_out),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .inflight     (inflight)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in0[16*i +: 16] = op0[i];
            req_in1[16*i +: 16] = op1[i];
        end
    end

    // Two-register DSP model, low 16 bits of the product.
    always @(posedge clk) begin
        dsp_p1 <= 16'(mul_in0 * mul_in1);
        dsp_p2 <= dsp_p1;
        cyc    <= cyc + 1;
    end
    assign mul_out = dsp_p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor/scoreboard: runs every cycle away from the active edge.
    always @(negedge clk) begin
        logic [3:0]  exp_rv;
        logic [15:0] exp_rd;
        logic [31:0] p;
        int          gid;
        exp_t        e;
        if (reset) begin
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_mvalid", 32'(mul_valid_in), 32'h0);
            q.delete();
            mptr = 0;
        end else begin
            chk("inflight", 32'(inflight), 32'(q.size()));
            exp_rv = 4'h0;
            exp_rd = 16'h0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv = 4'b0001 << e.id;
                exp_rd = e.prod;
            end
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv != 4'h0) begin
                chk("resp_data", 32'(resp_data), 32'(exp_rd));
                last_rd = resp_data;
                $display("resp cycle=%0d id=%0d data=%h", cyc, e.id, resp_data);
            end
            gid = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gid < 0 && req_valid[(mptr + k) % NUM_REQ])
                    gid = (mptr + k) % NUM_REQ;
            end
            if (gid >= 0) begin
                p = op0[gid] * op1[gid];
                chk("req_ready", 32'(req_ready), 32'(4'b0001 << gid));
                chk("mul_valid_in", 32'(mul_valid_in), 32'h1);
                chk("mul_in0", 32'(mul_in0), 32'(op0[gid]));
                chk("mul_in1", 32'(mul_in1), 32'(op1[gid]));
                q.push_back('{id: gid, prod: p[15:0], due: cyc + LATENCY});
                mptr = (gid + 1) % NUM_REQ;
                $display("issue cycle=%0d id=%0d %h*%h", cyc, gid, op0[gid], op1[gid]);
            end else begin
                chk("idle_ready", 32'(req_ready), 32'h0);
                chk("idle_mvalid", 32'(mul_valid_in), 32'h0);
                chk("idle_mul_in0", 32'(mul_in0), 32'h0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op0[i] = 16'(i + 1);
            op1[i] = 16'(i + 5);
        end
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Single request
        op0[0] = 16'd3; op1[0] = 16'd7; req_valid = 4'b0001;
        cycles(1);
        req_valid = '0;
        cycles(4);
        chk("t1_data", 32'(last_rd), 32'd21);

        // All requesters continuously valid with changing operands
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                op0[i] = 16'($urandom);
                op1[i] = 16'($urandom);
            end
            cycles(1);
        end
        req_valid = '0;
        cycles(4);

        // Requesters 1 and 3 only, starting from rr_ptr=2
        req_valid = 4'b0010;
        cycles(1);
        req_valid = 4'b1010;
        @(negedge clk); chk("t3_g0", 32'(req_ready), 32'h8);
        cycles(1);
        @(negedge clk); chk("t3_g1", 32'(req_ready), 32'h2);
        cycles(1);
        @(negedge clk); chk("t3_g2", 32'(req_ready), 32'h8);
        cycles(1);
        req_valid = '0;
        cycles(4);

        // Truncation to the low 16 bits
        op0[0] = 16'h0100; op1[0] = 16'h0100; req_valid = 4'b0001;
        cycles(1);
        req_valid = '0;
        cycles(4);
        chk("t4_ovf", 32'(last_rd), 32'h0000);
        op0[0] = 16'hFFFF; op1[0] = 16'h0002; req_valid = 4'b0001;
        cycles(1);
        req_valid = '0;
        cycles(4);
        chk("t4_neg", 32'(last_rd), 32'hFFFE);

        // Idle gap: pointer must survive 3 idle cycles
        op0[2] = 16'd9; op1[2] = 16'd11; req_valid = 4'b0100;
        cycles(1);
        req_valid = '0;
        cycles(3);
        req_valid = 4'b1111;
        @(negedge clk); chk("t6_ptr", 32'(req_ready), 32'h8);
        cycles(1);
        req_valid = '0;
        cycles(4);
        chk("t6_data", 32'(last_rd), 32'(16'(op0[3] * op1[3])));

        // Reset while the pipe is full
        req_valid = 4'b1111;
        cycles(4);
        @(negedge clk); chk("t5_full", 32'(inflight), 32'd2);
        cycles(1);
        reset = 1'b1;
        req_valid = 4'b0110;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_grant", 32'(req_ready), 32'h2);
        chk("t5_noresp0", 32'(resp_valid), 32'h0);
        cycles(1);
        req_valid = '0;
        @(negedge clk); chk("t5_noresp1", 32'(resp_valid), 32'h0);
        cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
